// File: rtl/octant_restore.sv
// Maps first-octant ray points back to the true octant, adds the ray origin and streams map cells (OCTANT_BOUNDS_EN adds range clamp + cell_oob).
// Latency: 2 cycles from point handshake to cell_valid; 1 cell/cycle sustained with cell_ready high.
// Backpressure: two-stage valid/ready pipeline, each stage loads when empty or draining; pt_ready falls once both stages are held.
module octant_restore #(
    parameter int COORD_W  = 16,
    parameter int OFF_W    = 12,
    parameter int LEN_W    = 12,
    parameter int MAP_SIZE = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ray_valid,
    output logic               ray_ready,
    input  logic [COORD_W-1:0] ray_origin_x,
    input  logic [COORD_W-1:0] ray_origin_y,
    input  logic               ray_flip_x,
    input  logic               ray_flip_y,
    input  logic               ray_flip_id,
    input  logic [LEN_W-1:0]   ray_length,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [OFF_W-1:0]   pt_x,
    input  logic [OFF_W-1:0]   pt_y,
    input  logic               pt_last,
    output logic               cell_valid,
    input  logic               cell_ready,
    output logic [COORD_W-1:0] cell_x,
    output logic [COORD_W-1:0] cell_y,
    output logic               cell_last,
    output logic               busy,
`ifdef OCTANT_BOUNDS_EN
    output logic               cell_oob,
`endif
    output logic               len_err
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    if (MAP_SIZE < 1 || MAP_SIZE > (1 << (COORD_W - 1))) begin : g_bad_map_size
        $error("MAP_SIZE must fit in the positive coordinate range");
    end

    state_t                    state;
    logic signed [COORD_W-1:0] org_x, org_y;
    logic                      flip_x, flip_y, flip_id;
    logic [LEN_W-1:0]          ray_len, pt_cnt, cnt_nxt;

    logic                      s1_vld, s1_last;
    logic signed [COORD_W-1:0] s1_x, s1_y;
    logic signed [COORD_W-1:0] ext_x, ext_y, tx, ty, res_x, res_y;
    logic                      s2_load, s1_free, pt_hs, cell_hs;

    assign s2_load  = !cell_valid || cell_ready;
    assign s1_free  = !s1_vld || s2_load;
    assign pt_ready = (state == STREAM) && s1_free;
    assign pt_hs    = pt_valid && pt_ready;
    assign cell_hs  = cell_valid && cell_ready;
    assign cnt_nxt  = pt_cnt + 1'b1;

    // Undo the reduction in reverse order: swap first, then the per-axis negations.
    always_comb begin
        ext_x = COORD_W'(pt_x);
        ext_y = COORD_W'(pt_y);
        tx    = flip_id ? ext_y : ext_x;
        ty    = flip_id ? ext_x : ext_y;
        if (flip_x) tx = -tx;
        if (flip_y) ty = -ty;
    end

`ifdef OCTANT_BOUNDS_EN
    localparam logic signed [COORD_W:0] MAP_MAX = (COORD_W + 1)'(MAP_SIZE - 1);
    logic signed [COORD_W:0] wide_x, wide_y;
    logic                    oob_x, oob_y;

    // One guard bit keeps the unsaturated sum exact for the range test.
    always_comb begin
        wide_x = {org_x[COORD_W-1], org_x} + {s1_x[COORD_W-1], s1_x};
        wide_y = {org_y[COORD_W-1], org_y} + {s1_y[COORD_W-1], s1_y};
        oob_x  = (wide_x < 0) || (wide_x > MAP_MAX);
        oob_y  = (wide_y < 0) || (wide_y > MAP_MAX);
        res_x  = (wide_x < 0) ? '0 : ((wide_x > MAP_MAX) ? MAP_MAX[COORD_W-1:0] : wide_x[COORD_W-1:0]);
        res_y  = (wide_y < 0) ? '0 : ((wide_y > MAP_MAX) ? MAP_MAX[COORD_W-1:0] : wide_y[COORD_W-1:0]);
    end
`else
    always_comb begin
        res_x = org_x + s1_x;
        res_y = org_y + s1_y;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_last    <= 1'b0;
            cell_valid <= 1'b0;
            cell_x     <= '0;
            cell_y     <= '0;
            cell_last  <= 1'b0;
`ifdef OCTANT_BOUNDS_EN
            cell_oob   <= 1'b0;
`endif
        end else begin
            if (s1_free) begin
                s1_vld <= pt_hs;
                if (pt_hs) begin
                    s1_x    <= tx;
                    s1_y    <= ty;
                    s1_last <= pt_last;
                end
            end
            if (s2_load) begin
                cell_valid <= s1_vld;
                if (s1_vld) begin
                    cell_x    <= res_x;
                    cell_y    <= res_y;
                    cell_last <= s1_last;
`ifdef OCTANT_BOUNDS_EN
                    cell_oob  <= oob_x || oob_y;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ray_ready <= 1'b1;
            busy      <= 1'b0;
            len_err   <= 1'b0;
            org_x     <= '0;
            org_y     <= '0;
            flip_x    <= 1'b0;
            flip_y    <= 1'b0;
            flip_id   <= 1'b0;
            ray_len   <= '0;
            pt_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ray_valid) begin
                        state     <= STREAM;
                        ray_ready <= 1'b0;
                        busy      <= 1'b1;
                        org_x     <= ray_origin_x;
                        org_y     <= ray_origin_y;
                        flip_x    <= ray_flip_x;
                        flip_y    <= ray_flip_y;
                        flip_id   <= ray_flip_id;
                        ray_len   <= ray_length;
                        pt_cnt    <= '0;
                        len_err   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (pt_hs) begin
                        pt_cnt <= cnt_nxt;
                        // pt_last ends the ray whatever the count says; mismatch only flags it.
                        if (pt_last) begin
                            state <= DRAIN;
                            if (cnt_nxt != ray_len) len_err <= 1'b1;
                        end else if (cnt_nxt == ray_len) begin
                            len_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (cell_hs && cell_last) begin
                        state     <= IDLE;
                        ray_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ray_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
